lw_pio_responder: RTL and testbench

- Avalon-MM slave on the HPS lightweight H2F bridge; the responder end of HPS-initiated register accesses.
- Drives the 8 board LEDs and samples the 4 slide switches.
- Adds switch synchronisation and debouncing, edge capture, an interrupt line, and per-LED hardware blink.
- Instantiated in the FPGA fabric beside the HPS system; LED and SW connect to the top-level pins.

---
 rtl/lw_pio_responder.sv | 153 +++++++++++++++
 tb/tb_lw_pio_responder.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_pio_responder.sv
// Avalon-MM LED/switch PIO responder on the HPS lightweight H2F bridge.
// Macro LW_PIO_IRQ_EN enables IRQ_MASK and the irq output; otherwise irq is tied low.
module lw_pio_responder #(
    parameter int LED_W           = 8,
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PERIOD_W        = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             irq
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        A_LED_DATA     = 3'd0,
        A_SW_STATE     = 3'd1,
        A_SW_EDGE      = 3'd2,
        A_IRQ_MASK     = 3'd3,
        A_BLINK_EN     = 3'd4,
        A_BLINK_PERIOD = 3'd5,
        A_RSVD6        = 3'd6,
        A_RSVD7        = 3'd7
    } reg_addr_e;

    reg_addr_e           addr;
    logic                wr_led, wr_edge, wr_en, wr_period, rd_go;
    logic [LED_W-1:0]    led_data, blink_en;
    logic [PERIOD_W-1:0] blink_period, blink_cnt;
    logic                blink_phase;
    logic [SW_W-1:0]     sync1, sync2, sw_state, sw_edge, irq_mask;
    logic [SW_W-1:0]     sw_changed, edge_clr;
    logic [DB_W-1:0]     db_cnt;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign addr         = reg_addr_e'(avs_address);
    assign wr_led       = avs_write && (addr == A_LED_DATA);
    assign wr_edge      = avs_write && (addr == A_SW_EDGE);
    assign wr_en        = avs_write && (addr == A_BLINK_EN);
    assign wr_period    = avs_write && (addr == A_BLINK_PERIOD);
    assign rd_go        = avs_read && !avs_write;
    assign unused_wdata = ^avs_writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_data     <= '0;
            blink_en     <= '0;
            blink_period <= '0;
        end else begin
            if (wr_led)    led_data     <= avs_writedata[LED_W-1:0];
            if (wr_en)     blink_en     <= avs_writedata[LED_W-1:0];
            if (wr_period) blink_period <= avs_writedata[PERIOD_W-1:0];
        end
    end

    // One shared counter: the whole vector is accepted once it has differed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sw_state <= '0;
            db_cnt   <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            if (sync2 == sw_state) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                sw_state <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign sw_changed = ((sync2 != sw_state) && (db_cnt == DB_LAST)) ? (sync2 ^ sw_state) : '0;
    assign edge_clr   = wr_edge ? avs_writedata[SW_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) sw_edge <= '0;
        else       sw_edge <= (sw_edge & ~edge_clr) | sw_changed;
    end

`ifdef LW_PIO_IRQ_EN
    logic wr_mask;
    assign wr_mask = avs_write && (addr == A_IRQ_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mask) irq_mask <= avs_writedata[SW_W-1:0];
            irq <= |(sw_edge & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || wr_period || (blink_period == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == blink_period - PERIOD_W'(1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) led_out <= '0;
        else       led_out <= led_data ^ (blink_en & {LED_W{blink_phase}});
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_LED_DATA:     rd_mux[LED_W-1:0]    = led_data;
            A_SW_STATE:     rd_mux[SW_W-1:0]     = sw_state;
            A_SW_EDGE:      rd_mux[SW_W-1:0]     = sw_edge;
            A_IRQ_MASK:     rd_mux[SW_W-1:0]     = irq_mask;
            A_BLINK_EN:     rd_mux[LED_W-1:0]    = blink_en;
            A_BLINK_PERIOD: rd_mux[PERIOD_W-1:0] = blink_period;
            default:        rd_mux               = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_go;
            avs_readdata      <= rd_go ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_lw_pio_responder.sv
// Self-checking bench for lw_pio_responder with a register-level reference model.
// Honours LW_PIO_IRQ_EN the same way the design does.
module tb_lw_pio_responder;
    localparam int LED_W = 8;
    localparam int SW_W  = 4;
    localparam int DEB   = 8;
    localparam int PW    = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       avs_address;
    logic             avs_read, avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic             avs_readdatavalid;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led_out;
    logic             irq;

    int errors = 0;
    int checks = 0;

    // Reference register state
    logic [31:0] m_led, m_sw, m_edge, m_mask, m_en, m_period;

    lw_pio_responder #(
        .LED_W(LED_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB), .PERIOD_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .sw_in(sw_in), .led_out(led_out), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_reg(input int a);
        case (a)
            0: return m_led;
            1: return m_sw;
            2: return m_edge;
            3: return m_mask;
            4: return m_en;
            5: return m_period;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_led = 0; m_sw = 0; m_edge = 0; m_mask = 0; m_en = 0; m_period = 0;
    endtask

    // Tasks start and end just after a falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b0;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        avs_address = a; avs_read = 1'b1; avs_write = 1'b0;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
        v = avs_readdatavalid;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        reset = 1'b1; sw_in = '0; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({avs_readdatavalid, avs_readdata, led_out, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdv=%b rd=%h led=%h irq=%b required all 0",
                     avs_readdatavalid, avs_readdata, led_out, irq);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d, v);
            checks++;
            if ({v, d} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL reset_read addr=%0d rdv=%b rd=%h required rdv=1 rd=0", a, v, d);
            end
            @(negedge clk);
            checks++;
            if (avs_readdatavalid !== 1'b0) begin
                errors++;
                $display("FAIL rdv_once addr=%0d rdv=%b required 0", a, avs_readdatavalid);
            end
        end
        checks++;
        if (led_out !== '0) begin
            errors++;
            $display("FAIL reset_led led=%h required 0", led_out);
        end
    endtask

    task automatic test_led();
        logic [31:0] d, val;
        logic v;
        bus_write(3'd0, 32'hA5);
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("FAIL led_lag led=%h required 00 (registered)", led_out);
        end
        @(negedge clk);
        checks++;
        if (led_out !== 8'hA5) begin
            errors++;
            $display("FAIL led_a5 led=%h required a5", led_out);
        end
        bus_read(3'd0, d, v);
        checks++;
        if ({v, d} !== {1'b1, 32'hA5}) begin
            errors++;
            $display("FAIL led_rb_a5 rdv=%b rd=%h required 1/000000a5", v, d);
        end
        bus_write(3'd0, 32'h1FF);
        bus_read(3'd0, d, v);
        checks++;
        if ({v, d} !== {1'b1, 32'hFF}) begin
            errors++;
            $display("FAIL led_rb_1ff rdv=%b rd=%h required 1/000000ff", v, d);
        end
        for (int i = 0; i < 6; i++) begin
            val = $urandom;
            bus_write(3'd0, val);
            @(negedge clk);
            checks++;
            if (led_out !== val[7:0]) begin
                errors++;
                $display("FAIL led_rand led=%h required %h", led_out, val[7:0]);
            end
        end
        m_led = {24'h0, val[7:0]};
    endtask

    task automatic test_regs_random();
        logic [31:0] d, wd;
        logic v;
        int a;
        for (int i = 0; i < 24; i++) begin
            a  = int'($urandom_range(0, 7));
            wd = $urandom;
            bus_write(3'(a), wd);
            case (a)
                0: m_led = wd & 32'hFF;
                2: m_edge = m_edge & ~wd;
`ifdef LW_PIO_IRQ_EN
                3: m_mask = wd & 32'hF;
`endif
                4: m_en = wd & 32'hFF;
                5: m_period = wd & 32'hFF_FFFF;
                default: ;
            endcase
        end
        for (int r = 0; r < 8; r++) begin
            bus_read(3'(r), d, v);
            checks++;
            if ({v, d} !== {1'b1, exp_reg(r)}) begin
                errors++;
                $display("FAIL reg_rand addr=%0d rdv=%b rd=%h required 1/%h", r, v, d, exp_reg(r));
            end
        end
        // read and write together: write wins, no read response
        wd = $urandom;
        avs_address = 3'd0; avs_writedata = wd; avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        m_led = wd & 32'hFF;
        checks++;
        if (avs_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rw_collide rdv=%b required 0", avs_readdatavalid);
        end
        bus_read(3'd0, d, v);
        checks++;
        if ({v, d} !== {1'b1, m_led}) begin
            errors++;
            $display("FAIL rw_collide_wr rd=%h required %h", d, m_led);
        end
        bus_write(3'd4, 32'h0); m_en = 0;
        bus_write(3'd5, 32'h0); m_period = 0;
    endtask

    task automatic test_debounce();
        logic [31:0] d, e;
        logic v;
        int glen[2] = '{5, 7};
        logic [3:0] nv, gl;
        // glitches of 5 and 7 (longest rejected) on sw[2]
        for (int g = 0; g < 2; g++) begin
            sw_in = 4'h4;
            repeat (glen[g]) @(posedge clk);
            @(negedge clk);
            sw_in = 4'h0;
            wait_cycles(12);
            bus_read(3'd1, d, v);
            bus_read(3'd2, e, v);
            checks++;
            if ({d, e} !== {m_sw, m_edge}) begin
                errors++;
                $display("FAIL deb_glitch len=%0d state=%h edge=%h required %h/%h",
                         glen[g], d, e, m_sw, m_edge);
            end
        end
        sw_in = 4'h4;
        wait_cycles(12);
        m_edge = m_edge | 32'h4; m_sw = 32'h4;
        bus_read(3'd1, d, v);
        bus_read(3'd2, e, v);
        checks++;
        if ({d, e} !== {32'h4, m_edge}) begin
            errors++;
            $display("FAIL deb_hold state=%h edge=%h required 4/%h", d, e, m_edge);
        end
        for (int i = 0; i < 4; i++) begin
            gl = 4'($urandom_range(1, 15));
            sw_in = m_sw[3:0] ^ gl;
            repeat ($urandom_range(1, 7)) @(posedge clk);
            @(negedge clk);
            sw_in = m_sw[3:0];
            wait_cycles(12);
            bus_read(3'd1, d, v);
            checks++;
            if (d !== m_sw) begin
                errors++;
                $display("FAIL deb_rand_glitch state=%h required %h", d, m_sw);
            end
            nv = 4'($urandom_range(0, 15));
            sw_in = nv;
            wait_cycles(12);
            m_edge = m_edge | (m_sw ^ {28'h0, nv});
            m_sw = {28'h0, nv};
            bus_read(3'd1, d, v);
            bus_read(3'd2, e, v);
            checks++;
            if ({d, e} !== {m_sw, m_edge}) begin
                errors++;
                $display("FAIL deb_rand state=%h edge=%h required %h/%h", d, e, m_sw, m_edge);
            end
        end
        bus_write(3'd2, 32'hF); m_edge = 0;
        bus_read(3'd2, e, v);
        checks++;
        if (e !== 32'h0) begin
            errors++;
            $display("FAIL edge_w1c edge=%h required 0", e);
        end
    endtask

    task automatic set_sw(input logic [3:0] nv);
        sw_in = nv;
        wait_cycles(14);
        m_edge = m_edge | (m_sw ^ {28'h0, nv});
        m_sw = {28'h0, nv};
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic v;
        set_sw(4'h0);
        bus_write(3'd2, 32'hF); m_edge = 0;
`ifdef LW_PIO_IRQ_EN
        bus_write(3'd3, 32'h4); m_mask = 32'h4;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle irq=%b required 0", irq); end
        set_sw(4'h4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set irq=%b required 1", irq); end
        bus_write(3'd2, 32'h4); m_edge = m_edge & ~32'h4;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_lag irq=%b required 1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr irq=%b required 0", irq); end
        set_sw(4'h5);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked irq=%b required 0", irq); end
        set_sw(4'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_fall irq=%b required 1", irq); end
        // debounced change lands on the 10th rising edge after sw_in moves; clear on that edge
        sw_in = 4'h5;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus_write(3'd2, 32'h4);
        m_edge = m_edge | 32'h4; m_sw = 32'h5;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL irq_set_wins cyc=%0d irq=%b required 1", i, irq);
            end
            @(negedge clk);
        end
        bus_read(3'd2, d, v);
        checks++;
        if (d !== m_edge) begin errors++; $display("FAIL edge_set_wins edge=%h required %h", d, m_edge); end
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mask_rb mask=%h required 4", d); end
        bus_write(3'd3, 32'h0); m_mask = 0;
`else
        bus_write(3'd3, 32'hF);
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mask_absent mask=%h required 0", d); end
        set_sw(4'h4);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied irq=%b required 0", irq); end
        bus_read(3'd2, d, v);
        checks++;
        if (d !== m_edge) begin errors++; $display("FAIL edge_noirq edge=%h required %h", d, m_edge); end
`endif
        bus_write(3'd2, 32'hF); m_edge = 0;
    endtask

    task automatic test_blink();
        logic [7:0] data, en, exp;
        int p, ph;
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin
                data = 8'h00; en = 8'h01; p = 4;
            end else begin
                data = 8'($urandom); en = 8'($urandom); p = int'($urandom_range(1, 6));
            end
            bus_write(3'd0, {24'h0, data});
            bus_write(3'd4, {24'h0, en});
            bus_write(3'd5, p);
            for (int k = 1; k <= 4 * p + 3; k++) begin
                @(negedge clk);
                ph  = ((k - 1) / p) % 2;
                exp = data ^ (ph != 0 ? en : 8'h00);
                checks++;
                if (led_out !== exp) begin
                    errors++;
                    $display("FAIL blink p=%0d k=%0d led=%h required %h", p, k, led_out, exp);
                end
            end
            bus_write(3'd5, 32'h0);
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (led_out !== data) begin
                    errors++;
                    $display("FAIL blink_stop k=%0d led=%h required %h", k, led_out, data);
                end
                @(negedge clk);
            end
        end
        m_led = {24'h0, data}; m_en = {24'h0, en}; m_period = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1, d2;
        logic v0, v1, v2, v3;
        bus_write(3'd4, 32'h0);
        bus_write(3'd0, 32'h3C);
        bus_write(3'd5, 32'h123456);
        set_sw(4'h9);
        avs_read = 1'b1; avs_address = 3'd0;
        @(negedge clk); d0 = avs_readdata; v0 = avs_readdatavalid; avs_address = 3'd1;
        @(negedge clk); d1 = avs_readdata; v1 = avs_readdatavalid; avs_address = 3'd5;
        @(negedge clk); d2 = avs_readdata; v2 = avs_readdatavalid; avs_read = 1'b0;
        @(negedge clk); v3 = avs_readdatavalid;
        checks++;
        if ({v0, d0} !== {1'b1, 32'h3C}) begin errors++; $display("FAIL b2b_0 rdv=%b rd=%h required 1/3c", v0, d0); end
        checks++;
        if ({v1, d1} !== {1'b1, 32'h9}) begin errors++; $display("FAIL b2b_1 rdv=%b rd=%h required 1/9", v1, d1); end
        checks++;
        if ({v2, d2} !== {1'b1, 32'h123456}) begin errors++; $display("FAIL b2b_2 rdv=%b rd=%h required 1/123456", v2, d2); end
        checks++;
        if (v3 !== 1'b0) begin errors++; $display("FAIL b2b_end rdv=%b required 0", v3); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic v;
        bus_write(3'd0, 32'h5A);
        bus_write(3'd4, 32'hF0);
        bus_write(3'd5, 32'h3);
        reset = 1'b1; avs_read = 1'b1; avs_address = 3'd0;
        @(negedge clk);
        checks++;
        if (avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rdv rdv=%b required 0", avs_readdatavalid); end
        reset = 1'b0; avs_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({led_out, irq, avs_readdatavalid} !== '0) begin
            errors++;
            $display("FAIL mid_rst_out led=%h irq=%b rdv=%b required 0", led_out, irq, avs_readdatavalid);
        end
        model_clear();
        for (int a = 1; a >= 0; a--) begin
            bus_read(3'(a), d, v);
            checks++;
            if ({v, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mid_rst_reg addr=%0d rd=%h required 0", a, d); end
        end
        for (int a = 2; a < 6; a++) begin
            bus_read(3'(a), d, v);
            checks++;
            if ({v, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mid_rst_reg addr=%0d rd=%h required 0", a, d); end
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_regs_random();
        test_debounce();
        test_irq();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
